data_mem_ctrl: RTL and testbench

- Next-generation RV32 data memory for the single-cycle/multicycle core.
- Word-organised RAM with parametrised depth and a valid/ready request port.
- Configurable wait states and a registered response.
- Full load/store set: LB, LH, LW, LBU, LHU, SB, SH, SW, using byte-lane alignment, sign/zero extension and access-error reporting.

---
 rtl/dmem_pkg.sv | 28 ++
 rtl/dmem_lane_align.sv | 58 +++++
 rtl/data_mem_ctrl.sv | 142 ++++++++++++++
 tb/tb_data_mem_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the RV32 data memory controller: funct3 codes,
// controller states and the word-index width helper.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    // Bits needed to index MEM_WORDS words (ceil(log2)).
    function automatic int idx_width(input int words);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < words) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32 loads/stores: byte enables, replicated write
// data, sign/zero-extended load data, misalignment and illegal-funct3 flags.
// Offending low address bits are always treated as zero here; whether a
// misaligned access is trapped is decided by the instantiating controller.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o,
    output logic        illegal_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rword_i[{addr_lo_i, 3'b000} +: 8];
    assign half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

    // Size decode on funct3[1:0]; funct3[2] selects zero extension for loads.
    always_comb begin
        be_o       = 4'b0000;
        wword_o    = wdata_i;
        rdata_o    = 32'h0;
        misalign_o = 1'b0;
        // Stores allow only 000/001/010; loads also allow 100/101.
        illegal_o  = (funct3_i[1:0] == 2'b11) | (funct3_i[2] & (we_i | funct3_i[1]));
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << addr_lo_i;
                wword_o = {4{wdata_i[7:0]}};
                rdata_o = funct3_i[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                misalign_o = addr_lo_i[0];
                be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wword_o    = {2{wdata_i[15:0]}};
                rdata_o    = funct3_i[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            2'b10: begin
                misalign_o = |addr_lo_i;
                be_o       = 4'b1111;
                wword_o    = wdata_i;
                rdata_o    = rword_i;
            end
            default: begin
                be_o = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// RV32 data memory: word-organised RAM behind a valid/ready request port,
// WAIT_STATES extra cycles before the access and a registered one-cycle
// response. Define DMEM_MISALIGN_TRAP_EN to report misaligned half/word
// accesses as errors instead of silently aligning them.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_WORDS   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err
);

    localparam int         IW      = idx_width(MEM_WORDS);
    localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [IW+1:0] addr_q;
    logic          we_q;
    logic [2:0]    f3_q;
    logic [31:0]   wdata_q;
    logic          resp_valid_q;
    logic [31:0]   resp_rdata_q;
    logic          resp_err_q;

    logic [31:0]   mem_q [MEM_WORDS];

    logic          accept;
    logic [31:0]   rword;
    logic [3:0]    be;
    logic [31:0]   wword;
    logic [31:0]   ld_data;
    logic          misalign;
    logic          illegal;
    logic          acc_err;
    logic          do_write;

    assign req_ready  = (state_q == IDLE) || (state_q == RESP);
    assign accept     = req_valid && req_ready;
    assign rword      = mem_q[addr_q[IW+1:2]];
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    dmem_lane_align u_align (
        .we_i       (we_q),
        .funct3_i   (f3_q),
        .addr_lo_i  (addr_q[1:0]),
        .wdata_i    (wdata_q),
        .rword_i    (rword),
        .be_o       (be),
        .wword_o    (wword),
        .rdata_o    (ld_data),
        .misalign_o (misalign),
        .illegal_o  (illegal)
    );

`ifdef DMEM_MISALIGN_TRAP_EN
    assign acc_err = illegal | misalign;
`else
    assign acc_err = illegal;
`endif

    assign do_write = (state_q == ACCESS) && we_q && !acc_err;

    // Next-state and wait-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WS_INIT;
                    end else begin
                        state_d = ACCESS;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = ACCESS;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ACCESS:  state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    // State, counter, request latch and registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            f3_q         <= 3'b000;
            wdata_q      <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= (state_q == ACCESS);
            if (accept) begin
                addr_q  <= req_addr[IW+1:0];
                we_q    <= req_we;
                f3_q    <= req_funct3;
                wdata_q <= req_wdata;
            end
            if (state_q == ACCESS) begin
                resp_rdata_q <= (!we_q && !acc_err) ? ld_data : 32'h0;
                resp_err_q   <= acc_err;
            end
        end
    end

    // RAM byte-lane write at the ACCESS edge; contents are not reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[addr_q[IW+1:2]][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed load/store scenarios plus
// randomized traffic against a byte-array reference model.
module tb_data_mem_ctrl;

    localparam int ADDR_WIDTH  = 32;
    localparam int MEM_WORDS   = 256;
    localparam int WAIT_STATES = 1;
    localparam int BYTES       = MEM_WORDS * 4;

    logic                  clk;
    logic                  rst_n;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_err;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem_b [BYTES];

    data_mem_ctrl #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .MEM_WORDS   (MEM_WORDS),
        .WAIT_STATES (WAIT_STATES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: RAM as bytes; returns {err, rdata} and applies stores.
    function automatic logic [32:0] model(input logic we, input logic [2:0] f3,
                                          input logic [31:0] addr, input logic [31:0] wd);
        int       size;
        int       nb;
        int       base;
        bit       legal;
        bit       mis;
        logic [31:0] v;
        size  = int'(f3[1:0]);
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        mis   = (size == 1 && addr[0]) || (size == 2 && addr[1:0] != 2'b00);
        if (!legal) return {1'b1, 32'h0};
`ifdef DMEM_MISALIGN_TRAP_EN
        if (mis) return {1'b1, 32'h0};
`endif
        nb   = 1 << size;
        base = int'(addr % BYTES);
        base = base - (base % nb);
        if (we) begin
            for (int i = 0; i < nb; i++) mem_b[base + i] = wd[8*i +: 8];
            return {1'b0, 32'h0};
        end
        v = 32'h0;
        for (int i = 0; i < nb; i++) v = v | (32'(mem_b[base + i]) << (8 * i));
        if (!f3[2] && nb < 4 && v[8*nb - 1]) v = v | ~((32'h1 << (8 * nb)) - 32'h1);
        return {1'b0, v};
    endfunction

    logic [31:0] last_rdata;

    // Issue one request (caller is at a ready cycle), wait for its response.
    task automatic xact(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
        logic [32:0] exp;
        int          k;
        check("ready_before_req", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        exp = model(we, f3, addr, wd);
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        k = 0;
        while (!resp_valid && k < 50) begin
            check("ready_busy", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
            k++;
        end
        check("latency", 32'(k), 32'(WAIT_STATES + 1));
        if (resp_valid) begin
            check("resp_rdata", resp_rdata, exp[31:0]);
            check("resp_err", 32'(resp_err), 32'(exp[32]));
            check("ready_in_resp", 32'(req_ready), 32'd1);
        end
        last_rdata = resp_rdata;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check("valid_idle", 32'(resp_valid), 32'd0);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = 32'h0;
        last_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        rst_n = 1'b1;
        idle(1);

        // Fill RAM so every later load has defined contents (back-to-back).
        for (int w = 0; w < MEM_WORDS; w++) xact(1'b1, 3'b010, 32'(w * 4), $urandom);
        idle(1);

        // Word store/load and extensions.
        xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        xact(1'b0, 3'b010, 32'h10, 32'h0);
        check("lw_deadbeef", last_rdata, 32'hDEADBEEF);
        xact(1'b0, 3'b000, 32'h13, 32'h0);
        check("lb_13", last_rdata, 32'hFFFFFFDE);
        xact(1'b0, 3'b100, 32'h13, 32'h0);
        check("lbu_13", last_rdata, 32'h000000DE);
        xact(1'b0, 3'b001, 32'h10, 32'h0);
        check("lh_10", last_rdata, 32'hFFFFBEEF);
        xact(1'b0, 3'b101, 32'h10, 32'h0);
        check("lhu_10", last_rdata, 32'h0000BEEF);
        idle(2);

        // Lane preservation.
        xact(1'b1, 3'b000, 32'h11, 32'hFFFFFF55);
        xact(1'b1, 3'b001, 32'h12, 32'hABCD1234);
        xact(1'b0, 3'b010, 32'h10, 32'h0);
        check("lanes_word", last_rdata, 32'h123455EF);

        // Misaligned accesses (trapped or aligned depending on build).
        xact(1'b0, 3'b010, 32'h12, 32'h0);
        xact(1'b1, 3'b001, 32'h11, 32'h00009876);
        xact(1'b0, 3'b010, 32'h10, 32'h0);

        // Illegal funct3, no write; then address wrap.
        xact(1'b0, 3'b011, 32'h10, 32'h0);
        xact(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF);
        xact(1'b1, 3'b110, 32'h14, 32'hFFFFFFFF);
        xact(1'b0, 3'b010, 32'h10, 32'h0);
        xact(1'b0, 3'b010, 32'h10 + 32'(BYTES), 32'h0);
        xact(1'b0, 3'b010, 32'h14, 32'h0);
        idle(1);

        // Reset during the wait of a store: no response, no write.
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h20;
        req_wdata  = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("midrst_valid", 32'(resp_valid), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("midrst_no_resp", 32'(resp_valid), 32'd0);
        end
        rst_n = 1'b1;
        idle(2);
        xact(1'b0, 3'b010, 32'h20, 32'h0);
        idle(1);

        // Randomized traffic, mixing back-to-back and idle gaps.
        for (int n = 0; n < 300; n++) begin
            xact(1'($urandom), 3'($urandom_range(0, 7)),
                 32'($urandom_range(0, 2 * BYTES - 1)), $urandom);
            idle($urandom_range(0, 2));
        end
        idle(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
